// File: rtl/fila_chamadas_if.sv
// Offer/acknowledge handshake between the call queue (master) and the motion controller (slave).
interface fila_chamadas_if;
  logic       req_valid;
  logic       req_ack;
  logic [1:0] dest;
  logic       subir;
  logic       descer;
  logic       chegou;

  modport master (output req_valid, dest, subir, descer, input req_ack, chegou);
  modport slave  (input req_valid, dest, subir, descer, output req_ack, chegou);
endinterface

// File: rtl/fila_chamadas.sv
// Elevator call queue: debounces active-low buttons, latches calls, tracks the floor
// and offers one SCAN-ordered destination at a time to the motion controller.
module fila_chamadas #(
  parameter int N_ANDARES  = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_ANDARES-1:0] b,
  input  logic [N_ANDARES-1:0] sen,
  fila_chamadas_if.master      ctl,
  output logic [N_ANDARES-1:0] pendente,
  output logic [1:0]           andar_atual,
  output logic                 erro_sensor
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {LIVRE, OFERTA, AGUARDA} estado_t;

  logic [N_ANDARES-1:0] b_s1_q, b_s1_d, b_s2_q, b_s2_d;
  logic [N_ANDARES-1:0] sen_s1_q, sen_s1_d, sen_s2_q, sen_s2_d;
  logic [N_ANDARES-1:0] deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [CW-1:0]        cnt_q [N_ANDARES];
  logic [CW-1:0]        cnt_d [N_ANDARES];
  logic [N_ANDARES-1:0] pend_q, pend_d;
  logic [1:0]           andar_q, andar_d;
  logic                 erro_q, erro_d;
  logic                 dir_sobe_q, dir_sobe_d;
  estado_t              estado_q, estado_d;
  logic                 valid_q, valid_d;
  logic [1:0]           dest_q, dest_d;
  logic                 subir_q, subir_d;
  logic                 descer_q, descer_d;

  logic [N_ANDARES-1:0] press, set_m, clr_m;
  logic [1:0]           acima, abaixo, alvo, idx_sen;
  logic                 acima_ok, abaixo_ok, dir_novo;
  int                   n_altos;

  always_comb begin
    b_s1_d     = b;
    b_s2_d     = b_s1_q;
    sen_s1_d   = sen;
    sen_s2_d   = sen_s1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < N_ANDARES; i++) begin
      cnt_d[i] = '0;
      if (b_s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEB_CYCLES - 1)) deb_d[i] = ~deb_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end

    // A press is the debounced level falling; it is seen one cycle after the flip.
    press = deb_prev_q & ~deb_q;
    set_m = press;
    clr_m = '0;
    for (int i = 0; i < N_ANDARES; i++) begin
      if (estado_q == LIVRE && pend_q == '0 && sen_s2_q[i] && andar_q == 2'(i)) set_m[i] = 1'b0;
      if (estado_q == AGUARDA && ctl.chegou && dest_q == 2'(i)) clr_m[i] = 1'b1;
    end
    pend_d = (pend_q | set_m) & ~clr_m;

    n_altos = 0;
    idx_sen = '0;
    for (int i = 0; i < N_ANDARES; i++) begin
      if (sen_s2_q[i]) begin
        n_altos = n_altos + 1;
        idx_sen = 2'(i);
      end
    end
    andar_d = (n_altos == 1) ? idx_sen : andar_q;
    erro_d  = erro_q | (n_altos > 1);

    // Nearest pending floor on each side of the car.
    acima    = '0;
    acima_ok = 1'b0;
    for (int i = N_ANDARES - 1; i >= 0; i--) begin
      if (pend_q[i] && 2'(i) > andar_q) begin
        acima    = 2'(i);
        acima_ok = 1'b1;
      end
    end
    abaixo    = '0;
    abaixo_ok = 1'b0;
    for (int i = 0; i < N_ANDARES; i++) begin
      if (pend_q[i] && 2'(i) < andar_q) begin
        abaixo    = 2'(i);
        abaixo_ok = 1'b1;
      end
    end

    alvo     = andar_q;
    dir_novo = dir_sobe_q;
    if (dir_sobe_q) begin
      if (acima_ok) alvo = acima;
      else if (abaixo_ok) begin
        alvo     = abaixo;
        dir_novo = 1'b0;
      end
    end else begin
      if (abaixo_ok) alvo = abaixo;
      else if (acima_ok) begin
        alvo     = acima;
        dir_novo = 1'b1;
      end
    end

    estado_d   = estado_q;
    valid_d    = valid_q;
    dest_d     = dest_q;
    subir_d    = subir_q;
    descer_d   = descer_q;
    dir_sobe_d = dir_sobe_q;
    case (estado_q)
      LIVRE: begin
        if (pend_q != '0) begin
          dest_d     = alvo;
          subir_d    = alvo > andar_q;
          descer_d   = alvo < andar_q;
          dir_sobe_d = dir_novo;
          valid_d    = 1'b1;
          estado_d   = OFERTA;
        end
      end
      OFERTA: begin
        if (ctl.req_ack) begin
          valid_d  = 1'b0;
          estado_d = AGUARDA;
        end
      end
      AGUARDA: begin
        if (ctl.chegou) begin
          subir_d  = 1'b0;
          descer_d = 1'b0;
          estado_d = LIVRE;
        end
      end
      default: estado_d = LIVRE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b_s1_q     <= '1;
      b_s2_q     <= '1;
      sen_s1_q   <= '0;
      sen_s2_q   <= '0;
      deb_q      <= '1;
      deb_prev_q <= '1;
      for (int i = 0; i < N_ANDARES; i++) cnt_q[i] <= '0;
      pend_q     <= '0;
      andar_q    <= '0;
      erro_q     <= 1'b0;
      dir_sobe_q <= 1'b1;
      estado_q   <= LIVRE;
      valid_q    <= 1'b0;
      dest_q     <= '0;
      subir_q    <= 1'b0;
      descer_q   <= 1'b0;
    end else begin
      b_s1_q     <= b_s1_d;
      b_s2_q     <= b_s2_d;
      sen_s1_q   <= sen_s1_d;
      sen_s2_q   <= sen_s2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      for (int i = 0; i < N_ANDARES; i++) cnt_q[i] <= cnt_d[i];
      pend_q     <= pend_d;
      andar_q    <= andar_d;
      erro_q     <= erro_d;
      dir_sobe_q <= dir_sobe_d;
      estado_q   <= estado_d;
      valid_q    <= valid_d;
      dest_q     <= dest_d;
      subir_q    <= subir_d;
      descer_q   <= descer_d;
    end
  end

  assign ctl.req_valid = valid_q;
  assign ctl.dest      = dest_q;
  assign ctl.subir     = subir_q;
  assign ctl.descer    = descer_q;
  assign pendente      = pend_q;
  assign andar_atual   = andar_q;
  assign erro_sensor   = erro_q;
endmodule

// File: tb/tb_fila_chamadas.sv
// Bench for fila_chamadas: directed scenarios plus random call traffic, offers checked by a scoreboard.
module tb_fila_chamadas;
  localparam int N   = 4;
  localparam int DEB = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] b     = '1;
  logic [N-1:0] sen   = 4'b0001;
  logic [N-1:0] pendente;
  logic [1:0]   andar_atual;
  logic         erro_sensor;

  fila_chamadas_if ctl ();

  fila_chamadas #(.N_ANDARES(N), .DEB_CYCLES(DEB)) dut (
    .clock(clock), .reset(reset), .b(b), .sen(sen), .ctl(ctl),
    .pendente(pendente), .andar_atual(andar_atual), .erro_sensor(erro_sensor)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0] d;
    logic       s;
    logic       de;
  } oferta_t;
  oferta_t esperado[$];

  // Reference: set of pending floors, car floor and travel direction.
  bit [N-1:0] m_pend;
  int         m_andar;
  bit         m_up;
  int         m_dest;

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
    end
  endtask

  // SCAN: search outward along the travel direction; if nothing, reverse and search again.
  function automatic void m_alvo(output int d, output bit s, output bit de);
    bit achou = 0;
    d = m_andar;
    for (int pass = 0; pass < 2 && !achou; pass++) begin
      int step = m_up ? 1 : -1;
      for (int f = m_andar + step; f >= 0 && f < N && !achou; f += step)
        if (m_pend[f]) begin
          d     = f;
          achou = 1;
        end
      if (!achou) m_up = !m_up;
    end
    s  = d > m_andar;
    de = d < m_andar;
  endfunction

  task automatic push_esperado();
    int d; bit s, de;
    oferta_t o;
    m_alvo(d, s, de);
    m_dest = d;
    o.d = 2'(d); o.s = s; o.de = de;
    esperado.push_back(o);
  endtask

  task automatic registra(input bit [N-1:0] mask);
    bit [N-1:0] ok = mask;
    if (m_pend == 0) ok[m_andar] = 1'b0;
    m_pend |= ok;
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic apertar(input bit [N-1:0] mask, input int hold);
    b = ~mask;
    ciclos(hold);
    b = '1;
    ciclos(10);
  endtask

  task automatic espera_valid(input logic nivel, input string nome);
    int k = 0;
    while (ctl.req_valid !== nivel && k < 80) begin
      @(negedge clock);
      k++;
    end
    if (ctl.req_valid !== nivel) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout, req_valid=%b required %b", nome, ctl.req_valid, nivel);
    end
  endtask

  task automatic servir(input bit [N-1:0] extra);
    espera_valid(1'b1, "valid_sobe");
    ciclos($urandom_range(0, 3));
    check("dest_estavel", 32'(ctl.dest), 32'(m_dest));
    ctl.req_ack = 1'b1;
    ciclos(1);
    ctl.req_ack = 1'b0;
    check("valid_apos_ack", 32'(ctl.req_valid), 32'(0));
    if (extra != 0) begin
      apertar(extra, 8);
      m_pend |= extra;
      check("pend_extra", 32'(pendente), 32'(m_pend));
    end
    sen = N'(1) << m_dest;
    ciclos(4);
    check("andar", 32'(andar_atual), 32'(m_dest));
    m_andar         = m_dest;
    m_pend[m_dest]  = 1'b0;
    if (m_pend != 0) push_esperado();
    ctl.chegou = 1'b1;
    ciclos(1);
    ctl.chegou = 1'b0;
    check("pend_limpo", 32'(pendente), 32'(m_pend));
    check("valid_1c", 32'(ctl.req_valid), 32'(0));
    if (m_pend != 0) begin
      ciclos(1);
      check("valid_2c", 32'(ctl.req_valid), 32'(1));
    end
  endtask

  // Scoreboard monitor: every new offer is compared against the oldest expectation.
  logic    vld_prev = 1'b0;
  oferta_t e_mon;
  always @(negedge clock) begin
    if (ctl.req_valid === 1'b1 && !vld_prev) begin
      if (esperado.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL oferta_inesperada: dest=%0d subir=%b descer=%b required no offer",
                 ctl.dest, ctl.subir, ctl.descer);
      end else begin
        e_mon = esperado.pop_front();
        check("oferta", 32'({ctl.dest, ctl.subir, ctl.descer}), 32'({e_mon.d, e_mon.s, e_mon.de}));
      end
    end
    vld_prev <= (ctl.req_valid === 1'b1);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl.req_ack = 1'b0;
    ctl.chegou  = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_valid", 32'(ctl.req_valid), 32'(0));
    check("rst_saidas", 32'({ctl.dest, ctl.subir, ctl.descer}), 32'(0));
    check("rst_pend", 32'(pendente), 32'(0));
    check("rst_andar_erro", 32'({andar_atual, erro_sensor}), 32'(0));
    ciclos(3);
    reset = 1'b1;
    ciclos(20);
    check("idle_andar", 32'(andar_atual), 32'(0));
    check("idle_pend", 32'(pendente), 32'(0));
    check("idle_valid", 32'(ctl.req_valid), 32'(0));
    m_pend = '0; m_andar = 0; m_up = 1'b1;

    // Single call from ground to floor 2, exact latency.
    registra(4'b0100);
    push_esperado();
    b[2] = 1'b0;
    ciclos(6);
    check("pend_c6", 32'(pendente), 32'(0));
    ciclos(1);
    check("pend_c7", 32'(pendente), 32'(4'b0100));
    check("valid_c7", 32'(ctl.req_valid), 32'(0));
    ciclos(1);
    check("valid_c8", 32'(ctl.req_valid), 32'(1));
    ciclos(2);
    b = '1;
    ciclos(10);
    servir('0);
    ciclos(10);
    check("valid_fica_0", 32'(ctl.req_valid), 32'(0));

    // Car at floor 1, calls at 0 and 3: up first, then back down.
    sen = 4'b0010;
    ciclos(4);
    m_andar = 1;
    check("andar_1", 32'(andar_atual), 32'(1));
    registra(4'b1001);
    push_esperado();
    apertar(4'b1001, 8);
    servir('0);
    servir('0);

    // Bouncing button never registers; a steady press does.
    for (int k = 0; k < 5; k++) begin
      b[1] = 1'b0; ciclos(2);
      b[1] = 1'b1; ciclos(2);
    end
    ciclos(8);
    check("bounce", 32'(pendente), 32'(0));
    registra(4'b0010);
    push_esperado();
    b[1] = 1'b0;
    ciclos(6);
    b[1] = 1'b1;
    ciclos(3);
    check("press_estavel", 32'(pendente), 32'(4'b0010));
    ciclos(7);
    servir('0);

    // New call during an offer; set and clear of the same floor in one cycle.
    registra(4'b0100);
    push_esperado();
    apertar(4'b0100, 8);
    m_pend |= 4'b0010;
    apertar(4'b0010, 8);
    check("pend_em_oferta", 32'(pendente), 32'(4'b0110));
    check("dest_em_oferta", 32'(ctl.dest), 32'(2));
    check("valid_em_oferta", 32'(ctl.req_valid), 32'(1));
    ctl.req_ack = 1'b1;
    ciclos(1);
    ctl.req_ack = 1'b0;
    sen = 4'b0100;
    ciclos(4);
    m_andar   = 2;
    m_pend[2] = 1'b0;
    push_esperado();
    b[2] = 1'b0;
    ciclos(6);
    ctl.chegou = 1'b1;
    ciclos(1);
    ctl.chegou = 1'b0;
    check("clear_vence", 32'(pendente), 32'(4'b0010));
    ciclos(2);
    b = '1;
    ciclos(10);
    servir('0);

    // Multiple sensors high: sticky error, floor held.
    sen = 4'b0110;
    ciclos(3);
    sen = 4'b0010;
    ciclos(4);
    check("erro_set", 32'(erro_sensor), 32'(1));
    check("erro_andar", 32'(andar_atual), 32'(1));
    ciclos(5);
    check("erro_sticky", 32'(erro_sensor), 32'(1));

    // Asynchronous reset while waiting for arrival.
    registra(4'b1000);
    push_esperado();
    apertar(4'b1000, 8);
    espera_valid(1'b1, "valid_pre_reset");
    ctl.req_ack = 1'b1;
    ciclos(1);
    ctl.req_ack = 1'b0;
    ciclos(2);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_valid", 32'(ctl.req_valid), 32'(0));
    check("rst_mid_saidas", 32'({ctl.dest, ctl.subir, ctl.descer}), 32'(0));
    check("rst_mid_pend", 32'(pendente), 32'(0));
    check("rst_mid_andar_erro", 32'({andar_atual, erro_sensor}), 32'(0));
    ciclos(2);
    reset = 1'b1;
    esperado.delete();
    m_pend = '0; m_up = 1'b1; m_andar = 1;
    ciclos(4);
    check("pos_rst_andar", 32'(andar_atual), 32'(1));

    // Random traffic.
    for (int it = 0; it < 25; it++) begin
      bit [N-1:0] mask;
      mask = N'($urandom_range(1, 15));
      registra(mask);
      if (m_pend == 0) begin
        apertar(mask, 8);
        check("pend_descartado", 32'(pendente), 32'(0));
      end else begin
        push_esperado();
        apertar(mask, 8);
        while (m_pend != 0) begin
          bit [N-1:0] extra;
          extra = '0;
          if ($urandom_range(0, 2) == 0) extra = N'($urandom_range(1, 15)) & ~(N'(1) << m_dest);
          servir(extra);
        end
      end
    end

    ciclos(5);
    check("fila_vazia", 32'(esperado.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fila_chamadas.md
Name: fila_chamadas

Overview:
- Upstream stage of the elevator controller: turns raw active-low floor-call buttons and floor sensors into one destination request at a time.
- Synchronises and debounces the buttons, latches pending calls and tracks the current floor.
- Picks the next destination in SCAN order (keep direction while calls remain ahead) and hands it to the controller over a valid/ack handshake.
- Clears a call when the controller reports arrival.

Parameters:
N_ANDARES, 4, number of floors; index 0 = ground. The dest and andar_atual widths are fixed at 2 bits, so this must be ≤ 4.
DEB_CYCLES, 4, consecutive identical synchronised samples needed to accept a button level change.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
b  input  N_ANDARES  raw call buttons, active-low (b[i]=0 means floor i pressed)
sen  input  N_ANDARES  raw floor sensors, active-high, expected one-hot or zero
chegou  input  1  one-cycle pulse from controller: stopped at offered destination, door opening
req_valid  output  1  destination offer valid
req_ack  input  1  controller accepts the offer
dest  output  2  offered destination floor, binary
subir  output  1  offered move is upward
descer  output  1  offered move is downward
pendente  output  N_ANDARES  latched pending calls (drives LEDs)
andar_atual  output  2  last valid floor from sensors, binary
erro_sensor  output  1  sticky: more than one sensor was seen active at once

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - req_valid=0, dest=0, subir=0, descer=0, pendente=0, andar_atual=0, erro_sensor=0.
  - Direction register dir=up, FSM in LIVRE.
  - All synchroniser flops cleared to the idle (inactive) level; debounce counters cleared.
- Synchronisation: b and sen each pass through 2 flops before use.
- Debounce, per button:
  - The counter increments while the synced sample differs from the debounced level and resets to 0 when they match.
  - On reaching DEB_CYCLES, the debounced level flips and the counter clears.
  - A press event is the debounced transition from 1 to 0.
  - Latency from a raw press to pendente[i]=1 is 2 + DEB_CYCLES + 1 cycles.
- Latching a call:
  - A press event sets pendente[i].
  - Exception: the press is dropped when the FSM is in LIVRE, pendente is 0, the synced sen[i]=1 and andar_atual=i (car already there).
  - If a set and a clear of the same bit occur in the same cycle, the clear wins.
- Floor tracking:
  - Exactly one synced sensor high: andar_atual ← its index.
  - No sensor high: andar_atual holds.
  - Two or more high: andar_atual holds and erro_sensor ← 1 until reset.
- FSM LIVRE:
  - If pendente≠0, compute the target from the current pendente, andar_atual and dir, then latch dest, subir and descer.
  - Target selection when dir=up:
    - Lowest pending floor strictly above andar_atual.
    - Else the highest pending floor strictly below, and dir ← down.
    - Else (only andar_atual pending) dest=andar_atual with subir=descer=0.
  - dir=down is the mirror image.
  - subir=1 if dest>andar_atual; descer=1 if dest<andar_atual.
  - Next state OFERTA; req_valid rises 1 cycle after pendente becomes nonzero.
- FSM OFERTA:
  - req_valid=1; dest, subir and descer are held stable even if new calls arrive.
  - On req_ack=1: req_valid ← 0 and go to AGUARDA.
- FSM AGUARDA:
  - On chegou=1: clear pendente[dest], clear subir and descer, go to LIVRE.
  - chegou while in LIVRE or OFERTA is ignored.
  - New calls keep latching in every state.
- Back-to-back service: after the clear in AGUARDA, the next offer appears 2 cycles after chegou (LIVRE, then OFERTA).
- Reset while in OFERTA or AGUARDA: all pending calls are lost, req_valid drops immediately and asynchronously.

Test Plan:
- Reset low, then high with all b=1 and sen=0001 → after sync, andar_atual=0, pendente=0, req_valid=0 indefinitely.
- Car at floor 0. Press b[2] for 10 cycles → pendente=0100 at cycle 7; req_valid=1 at cycle 8 with dest=2, subir=1. After req_ack, chegou → pendente=0000 and req_valid stays 0.
- Car at floor 1, dir=up, pendente=1001 (floors 0 and 3) → offer dest=3, subir=1. After ack and chegou with sen=1000 → next offer dest=0 with descer=1, 2 cycles after chegou.
- Bounce test: b[1] toggles every 2 cycles for 20 cycles (DEB_CYCLES=4) → pendente[1] stays 0. A steady low for 6 cycles then sets it.
- In OFERTA with dest=2, a new press of floor 1 latches pendente[1] while dest stays 2. Press floor 2 in the same cycle as the chegou that clears it → pendente[2]=0.
- sen=0110 for 3 cycles → erro_sensor=1 stays set and andar_atual unchanged. Asserting reset mid-AGUARDA → every output returns to its reset value immediately.
